// File: rtl/exec_flag_sequencer_pkg.sv
// Shared definitions for the execute-stage flag sequencer: ALU op one-hot codes,
// condition codes, execution-unit encodings and the sequencer state enum.
package exec_flag_sequencer_pkg;

  localparam logic [6:0] OP_ADD = 7'b1000000;
  localparam logic [6:0] OP_SUB = 7'b0100000;
  localparam logic [6:0] OP_CMP = 7'b0010000;
  localparam logic [6:0] OP_AND = 7'b0001000;
  localparam logic [6:0] OP_ORR = 7'b0000100;
  localparam logic [6:0] OP_EOR = 7'b0000010;
  localparam logic [6:0] OP_MOV = 7'b0000001;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  // Bit positions inside the PSR flag nibble
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    UNIT_ALU     = 2'b00,
    UNIT_SHIFT   = 2'b01,
    UNIT_MULT    = 2'b10,
    UNIT_ILLEGAL = 2'b11
  } unit_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_EXEC      = 2'b01,
    ST_MULT_WAIT = 2'b10
  } state_e;

  function automatic logic is_onehot7(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

endpackage

// File: rtl/exec_flag_sequencer_cond_eval.sv
// Combinational condition-code check of an instruction's cond field against
// the current PSR flags.
module cond_eval
  import exec_flag_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic z_s, n_s, c_s, v_s;

  assign z_s = flags[FLAG_Z];
  assign n_s = flags[FLAG_N];
  assign c_s = flags[FLAG_C];
  assign v_s = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ:   pass = z_s;
      CC_NE:   pass = !z_s;
      CC_CS:   pass = c_s;
      CC_CC:   pass = !c_s;
      CC_MI:   pass = n_s;
      CC_PL:   pass = !n_s;
      CC_VS:   pass = v_s;
      CC_VC:   pass = !v_s;
      CC_HI:   pass = c_s && !z_s;
      CC_LS:   pass = !c_s || z_s;
      CC_GE:   pass = (n_s == v_s);
      CC_LT:   pass = (n_s != v_s);
      CC_GT:   pass = !z_s && (n_s == v_s);
      CC_LE:   pass = z_s || (n_s != v_s);
      CC_AL:   pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_flag_sequencer.sv
// Execute-stage sequencer: accepts one instruction, resolves its condition and
// steers ALU / shifter / multiplier results into the PSR and register file.
module exec_flag_sequencer
  import exec_flag_sequencer_pkg::*;
#(
  parameter int MULT_TIMEOUT = 31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  logic [3:0] cond,
  input  logic [1:0] unit,
  input  logic [6:0] op_sel,
  input  logic       set_flags,
  input  logic [3:0] flag_in,
  output logic       mult_start,
  input  logic       mult_done,
  output logic [6:0] alu_sel,
  output logic       shift,
  output logic       mult,
  output logic       psr_wen,
  output logic       rf_wen,
  output logic       cond_fail,
  output logic       err
);

  state_e     state_q, state_d;
  logic [3:0] cond_q, cond_d;
  unit_e      unit_q, unit_d;
  logic [6:0] op_q, op_d;
  logic       sf_q, sf_d;
  logic [4:0] cnt_q, cnt_d;

  logic pass_s;
  logic illegal_s;
  logic expired_s;

  cond_eval u_cond_eval (
    .cond  (cond_q),
    .flags (flag_in),
    .pass  (pass_s)
  );

  // Illegal encodings only matter once the condition has passed
  assign illegal_s = (unit_q == UNIT_ILLEGAL) ||
                     ((unit_q == UNIT_ALU) && !is_onehot7(op_q));
  assign expired_s = (cnt_q == 5'(MULT_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cond_q  <= 4'd0;
      unit_q  <= UNIT_ALU;
      op_q    <= 7'd0;
      sf_q    <= 1'b0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
      unit_q  <= unit_d;
      op_q    <= op_d;
      sf_q    <= sf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    unit_d  = unit_q;
    op_d    = op_q;
    sf_d    = sf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_valid) begin
          state_d = ST_EXEC;
          cond_d  = cond;
          unit_d  = unit_e'(unit);
          op_d    = op_sel;
          sf_d    = set_flags;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (pass_s && !illegal_s && (unit_q == UNIT_MULT)) begin
          state_d = ST_MULT_WAIT;
          cnt_d   = 5'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MULT_WAIT: begin
        if (mult_done || expired_s) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    issue_ready = 1'b0;
    mult_start  = 1'b0;
    alu_sel     = 7'd0;
    shift       = 1'b0;
    mult        = 1'b0;
    psr_wen     = 1'b0;
    rf_wen      = 1'b0;
    cond_fail   = 1'b0;
    err         = 1'b0;
    case (state_q)
      ST_IDLE: issue_ready = 1'b1;
      ST_EXEC: begin
        if (!pass_s) begin
          cond_fail = 1'b1;
        end else if (illegal_s) begin
          err = 1'b1;
        end else begin
          case (unit_q)
            UNIT_ALU: begin
              alu_sel = op_q;
              psr_wen = (op_q == OP_CMP) ? 1'b1 : ((op_q == OP_MOV) ? 1'b0 : sf_q);
              rf_wen  = (op_q != OP_CMP);
            end
            UNIT_SHIFT: begin
              shift   = 1'b1;
              psr_wen = sf_q;
              rf_wen  = 1'b1;
            end
            UNIT_MULT: mult_start = 1'b1;
            default:   err = 1'b1;
          endcase
        end
      end
      ST_MULT_WAIT: begin
        if (mult_done) begin
          mult    = 1'b1;
          psr_wen = sf_q;
          rf_wen  = 1'b1;
        end else if (expired_s) begin
          err = 1'b1;
        end else begin
          err = 1'b0;
        end
      end
      default: issue_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_exec_flag_sequencer.sv
// Directed self-checking bench for exec_flag_sequencer with hand-computed expectations.
module tb_exec_flag_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic       issue_ready;
  logic [3:0] cond;
  logic [1:0] unit;
  logic [6:0] op_sel;
  logic       set_flags;
  logic [3:0] flag_in;
  logic       mult_start;
  logic       mult_done;
  logic [6:0] alu_sel;
  logic       shift, mult, psr_wen, rf_wen, cond_fail, err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  exec_flag_sequencer #(.MULT_TIMEOUT(31)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .cond(cond), .unit(unit), .op_sel(op_sel), .set_flags(set_flags), .flag_in(flag_in),
    .mult_start(mult_start), .mult_done(mult_done), .alu_sel(alu_sel), .shift(shift),
    .mult(mult), .psr_wen(psr_wen), .rf_wen(rf_wen), .cond_fail(cond_fail), .err(err)
  );

  always #5 clk = ~clk;

  // Output bundle: {alu_sel, shift, mult, psr_wen, rf_wen, mult_start, cond_fail, err}
  function automatic logic [13:0] exp_o(input logic [6:0] a, input logic sh, input logic mu,
                                        input logic pw, input logic rw, input logic ms,
                                        input logic cf, input logic er);
    return {a, sh, mu, pw, rw, ms, cf, er};
  endfunction

  function automatic logic [13:0] obs_o();
    return {alu_sel, shift, mult, psr_wen, rf_wen, mult_start, cond_fail, err};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Offer one instruction in IDLE; returns #1 into the EXEC cycle
  task automatic issue(input logic [3:0] c, input logic [1:0] u, input logic [6:0] op,
                       input logic s, input logic [3:0] fl);
    @(negedge clk);
    cond = c; unit = u; op_sel = op; set_flags = s; issue_valid = 1'b1;
    #1 check_eq("ready_before_issue", 16'(issue_ready), 16'd1);
    @(negedge clk);
    issue_valid = 1'b0; flag_in = fl;
    cond = 4'd0; unit = 2'd0; op_sel = 7'd0; set_flags = 1'b0;
    #1;
  endtask

  task automatic back_to_idle(input string tag);
    @(negedge clk);
    #1 check_eq({tag, "_ready"}, 16'(issue_ready), 16'd1);
    check_eq({tag, "_idle_out"}, 16'(obs_o()), 16'd0);
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; cond = 4'd0; unit = 2'd0; op_sel = 7'd0;
    set_flags = 1'b0; flag_in = 4'd0; mult_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check_eq("reset_ready", 16'(issue_ready), 16'd1);
    check_eq("reset_out", 16'(obs_o()), 16'd0);

    // ADD AL S=1
    issue(4'hE, 2'b00, 7'b1000000, 1'b1, 4'b0000);
    check_eq("add_exec", 16'(obs_o()), 16'(exp_o(7'b1000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)));
    check_eq("add_ready_busy", 16'(issue_ready), 16'd0);
    back_to_idle("add");

    // CMP EQ with Z=0 -> squashed
    issue(4'h0, 2'b00, 7'b0010000, 1'b0, 4'b0000);
    check_eq("cmp_eq_fail", 16'(obs_o()), 16'(exp_o(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));
    back_to_idle("cmp_fail");

    // CMP EQ with Z=1 -> flags only
    issue(4'h0, 2'b00, 7'b0010000, 1'b0, 4'b1000);
    check_eq("cmp_eq_pass", 16'(obs_o()), 16'(exp_o(7'b0010000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)));

    // MOV S=1 -> no PSR write
    issue(4'hE, 2'b00, 7'b0000001, 1'b1, 4'b0000);
    check_eq("mov_s1", 16'(obs_o()), 16'(exp_o(7'b0000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)));

    // SUB GT with N=V=1, Z=0 -> pass, S=0
    issue(4'hC, 2'b00, 7'b0100000, 1'b0, 4'b0101);
    check_eq("sub_gt", 16'(obs_o()), 16'(exp_o(7'b0100000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)));

    // AND LE with N=1, V=0 -> pass, S=1
    issue(4'hD, 2'b00, 7'b0001000, 1'b1, 4'b0100);
    check_eq("and_le", 16'(obs_o()), 16'(exp_o(7'b0001000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)));

    // HI with C=1, Z=1 -> fail
    issue(4'h8, 2'b00, 7'b0000100, 1'b1, 4'b1010);
    check_eq("orr_hi_fail", 16'(obs_o()), 16'(exp_o(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));

    // cond=1111 never passes
    issue(4'hF, 2'b00, 7'b0000010, 1'b1, 4'b1111);
    check_eq("eor_nv_fail", 16'(obs_o()), 16'(exp_o(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));

    // Shifter CC with C=0, S=1
    issue(4'h3, 2'b01, 7'b0000000, 1'b1, 4'b0000);
    check_eq("shift_cc", 16'(obs_o()), 16'(exp_o(7'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)));
    back_to_idle("shift");

    // Non-one-hot op with ALU
    issue(4'hE, 2'b00, 7'b0000011, 1'b1, 4'b0000);
    check_eq("ill_op", 16'(obs_o()), 16'(exp_o(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));

    // Illegal unit
    issue(4'hE, 2'b11, 7'b1000000, 1'b1, 4'b0000);
    check_eq("ill_unit", 16'(obs_o()), 16'(exp_o(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));

    // Illegal op but failing condition -> squash wins
    issue(4'h1, 2'b00, 7'b0000011, 1'b1, 4'b1000);
    check_eq("ill_op_cond_fail", 16'(obs_o()), 16'(exp_o(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));

    // MUL S=1, done on 4th wait cycle
    issue(4'hE, 2'b10, 7'b0000000, 1'b1, 4'b0000);
    check_eq("mul_start", 16'(obs_o()), 16'(exp_o(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check_eq("mul_wait", 16'(obs_o()), 16'd0);
    end
    @(negedge clk);
    mult_done = 1'b1;
    #1 check_eq("mul_done", 16'(obs_o()), 16'(exp_o(7'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)));
    @(negedge clk);
    mult_done = 1'b0;
    #1 check_eq("mul_done_ready", 16'(issue_ready), 16'd1);

    // MUL timeout: 31 wait cycles, err in the last
    issue(4'hE, 2'b10, 7'b0000000, 1'b1, 4'b0000);
    check_eq("mul_to_start", 16'(obs_o()), 16'(exp_o(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1 check_eq("mul_to_wait", 16'(obs_o()), 16'd0);
    end
    @(negedge clk);
    #1 check_eq("mul_to_err", 16'(obs_o()), 16'(exp_o(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));
    back_to_idle("mul_to");

    // MUL S=0, done arrives in the expiry cycle -> done wins
    issue(4'hE, 2'b10, 7'b0000000, 1'b0, 4'b0000);
    for (int i = 0; i < 30; i++) @(negedge clk);
    @(negedge clk);
    mult_done = 1'b1;
    #1 check_eq("mul_done_at_expiry", 16'(obs_o()), 16'(exp_o(7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)));
    @(negedge clk);
    mult_done = 1'b0;
    #1 check_eq("mul_expiry_ready", 16'(issue_ready), 16'd1);

    // Reset during MULT_WAIT abandons the multiply
    issue(4'hE, 2'b10, 7'b0000000, 1'b1, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mult_done = 1'b1;
    #1 check_eq("rst_wait_out", 16'(obs_o()), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check_eq("rst_wait_ready", 16'(issue_ready), 16'd1);
    check_eq("rst_wait_nowrite", 16'(obs_o()), 16'd0);
    @(negedge clk);
    mult_done = 1'b0;
    #1 check_eq("rst_wait_idle", 16'(obs_o()), 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/exec_flag_sequencer.md
EXEC_FLAG_SEQUENCER -- requirements
Module: exec_flag_sequencer

Interface
REQ-001 SHALL have parameter MULT_TIMEOUT, default 31: max wait cycles for mult_done before abort (legal range 1..31).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  instruction offered
- issue_ready  out  1  sequencer can accept
- cond  in  4  condition code
- unit  in  2  execution unit: 00 ALU, 01 shifter, 10 multiplier, 11 illegal
- op_sel  in  7  one-hot ALU op {ADD,SUB,CMP,AND,ORR,EOR,MOV}, MSB = ADD
- set_flags  in  1  S bit
- flag_in  in  4  current PSR flags: [3]=Z, [2]=N, [1]=C, [0]=V
- mult_start  out  1  one-cycle multiplier start pulse
- mult_done  in  1  multiplier result and flags valid
- alu_sel  out  7  op select to ALU/PSR
- shift  out  1  shifter flags select
- mult  out  1  multiplier flags select
- psr_wen  out  1  PSR write enable
- rf_wen  out  1  register-file write enable
- cond_fail  out  1  pulse: instruction squashed
- err  out  1  pulse: illegal op or multiplier timeout

Function
REQ-003 SHALL implement FSM states IDLE, EXEC, MULT_WAIT.
REQ-004 SHALL assert issue_ready only in IDLE; accept on issue_valid && issue_ready, latch cond/unit/op_sel/set_flags, then enter EXEC.
REQ-005 SHALL evaluate cond in EXEC against flag_in sampled that cycle: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 never.
REQ-006 SHALL, on cond fail in EXEC, pulse cond_fail for 1 cycle, keep psr_wen/rf_wen/mult_start low, return to IDLE.
REQ-007 SHALL, on pass with unit ALU, drive alu_sel = latched op_sel in EXEC; psr_wen = 1 for CMP, set_flags for other ops except MOV (0); rf_wen = 1 except CMP; then return to IDLE.
REQ-008 SHALL, on pass with unit shifter, drive shift=1, psr_wen=set_flags, rf_wen=1 in EXEC; then return to IDLE.
REQ-009 SHALL, on pass with unit multiplier, pulse mult_start in EXEC with no writes, then enter MULT_WAIT.
REQ-010 SHALL sample mult_done only in MULT_WAIT; in the cycle mult_done=1: drive mult=1, psr_wen=set_flags, rf_wen=1, return to IDLE.
REQ-011 SHALL count MULT_WAIT cycles with a 5-bit counter cleared on entry; if MULT_TIMEOUT cycles elapse without mult_done: pulse err, no writes, return to IDLE; mult_done in the same cycle as expiry wins.
REQ-012 SHALL treat unit=11 or non-one-hot op_sel with unit ALU (checked only if cond passes) as illegal: pulse err, no writes, return to IDLE.
REQ-013 SHALL hold alu_sel=0 and shift/mult/psr_wen/rf_wen/mult_start/cond_fail/err=0 in every cycle not named above.
REQ-014 SHALL complete ALU/shifter instructions in 2 cycles (accept + EXEC) and accept no new instruction until back in IDLE.

Reset
REQ-015 SHALL, on reset=1 at a rising clk, go to IDLE, clear latched fields and the counter, and drive every output 0 except issue_ready, which is 1 the cycle after reset.
REQ-016 SHALL, on reset in MULT_WAIT, abandon the pending multiply with no psr_wen/rf_wen/err.

Structure
REQ-017 SHALL take from a shared package: the one-hot ALU op constants, condition-code constants, unit encodings and the FSM state enum.
REQ-018 SHALL put condition evaluation in one combinational sub-module, cond_eval (cond, flags -> pass).

Verification
REQ-019 ADD, cond=AL, S=1 -> next cycle alu_sel=7'b1000000, psr_wen=1, rf_wen=1; issue_ready high again the following cycle.
REQ-020 CMP, cond=EQ, flag_in=4'b0000 -> cond_fail pulse, psr_wen=0, rf_wen=0.
REQ-021 MUL, S=1, cond=AL, mult_done after 4 cycles -> one mult_start, then mult=1, psr_wen=1, rf_wen=1 in the done cycle.
REQ-022 MUL, mult_done never asserted -> err pulse after MULT_TIMEOUT (31) wait cycles, no writes, issue_ready returns.
REQ-023 op_sel=7'b0000011 with unit ALU, and separately unit=11 -> err pulse, no writes; MOV with S=1 -> psr_wen=0, rf_wen=1.
REQ-024 reset asserted in MULT_WAIT, then mult_done=1 -> no psr_wen/rf_wen; issue_ready=1 the cycle after reset.
